// File: rtl/iob_rr_arbiter_pkg.sv
// Shared types and helpers for the IOb round-robin arbiter.
// Optional feature macro: IOB_RR_ARBITER_LOCK_EN (see iob_rr_arbiter.sv).
package iob_rr_arbiter_pkg;

    // ARB picks a new winner each cycle; HOLD pins the grant until the slave accepts.
    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Width of a master index; a single master still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_arb_owner_fifo.sv
// Register FIFO recording which master owns each outstanding read,
// oldest entry at the head.
module iob_arb_owner_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign pop_ok  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO is still safe then.
    assign push_ok = push_i & (~full_o | pop_ok);

    // Next pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
        if (!arst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    // NOTE: the storage array has no reset; occupancy is reset, so stale entries are never read out.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter sharing one IOb slave among N_MASTERS IOb masters.
// Reads may be outstanding; an owner FIFO routes each rvalid back to its issuer.
// Optional build macro IOB_RR_ARBITER_LOCK_EN adds m_lock_i for locked sequences.
module iob_rr_arbiter
    import iob_rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS       = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk_i,
    input  logic                          arst_n_i,
    input  logic                          cke_i,
`ifdef IOB_RR_ARBITER_LOCK_EN
    input  logic [N_MASTERS-1:0]          m_lock_i,
`endif
    input  logic [N_MASTERS-1:0]          m_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
    output logic [N_MASTERS-1:0]          m_ready_o,
    output logic [N_MASTERS-1:0]          m_rvalid_o,
    output logic [DATA_W-1:0]             m_rdata_o,
    output logic                          s_avalid_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_wdata_o,
    output logic [DATA_W/8-1:0]           s_wstrb_o,
    input  logic                          s_ready_i,
    input  logic                          s_rvalid_i,
    input  logic [DATA_W-1:0]             s_rdata_i,
    output logic                          err_o
);

    localparam int ID_W   = id_width(N_MASTERS);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e           state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      hold_id_q, hold_id_d;
    logic                 err_q, err_d;
    logic [N_MASTERS-1:0] is_write, eligible;
    logic [ID_W-1:0]      grant;
    logic                 grant_vld;
    int                   scan_idx;
    logic                 handshake;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ID_W-1:0]      fifo_head;

`ifdef IOB_RR_ARBITER_LOCK_EN
    logic                 lock_q, lock_d;
    logic [ID_W-1:0]      lock_id_q, lock_id_d;
`endif

    // Reads need a free owner slot; writes never do.
    always_comb begin
        is_write = '0;
        eligible = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            is_write[k] = |m_wstrb_i[k*STRB_W +: STRB_W];
            eligible[k] = m_avalid_i[k] & (is_write[k] | ~fifo_full);
        end
    end

    // Grant selection: held grant, locked owner, or first eligible after ptr.
    always_comb begin
        grant     = hold_id_q;
        grant_vld = 1'b0;
        scan_idx  = 0;
        if (state_q == HOLD) begin
            grant     = hold_id_q;
            grant_vld = m_avalid_i[hold_id_q];
        end
`ifdef IOB_RR_ARBITER_LOCK_EN
        else if (lock_q) begin
            grant     = lock_id_q;
            grant_vld = eligible[lock_id_q];
        end
`endif
        else begin
            for (int i = 1; i <= N_MASTERS; i++) begin
                scan_idx = (int'(ptr_q) + i) % N_MASTERS;
                if (!grant_vld && eligible[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant     = ID_W'(scan_idx);
                end
            end
        end
    end

    // Request path: forward the winner; everything is forced quiet while reset is asserted.
    always_comb begin
        s_avalid_o = grant_vld & arst_n_i;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        s_wstrb_o  = '0;
        m_ready_o  = '0;
        if (s_avalid_o) begin
            s_addr_o  = m_addr_i[int'(grant)*ADDR_W +: ADDR_W];
            s_wdata_o = m_wdata_i[int'(grant)*DATA_W +: DATA_W];
            s_wstrb_o = m_wstrb_i[int'(grant)*STRB_W +: STRB_W];
        end
        m_ready_o[grant] = s_avalid_o & s_ready_i;
    end

    assign handshake = s_avalid_o & s_ready_i;
    assign fifo_push = handshake & ~is_write[grant] & cke_i;
    assign fifo_pop  = s_rvalid_i & ~fifo_empty & cke_i;

    // Response path: route slave read data to the oldest outstanding owner.
    always_comb begin
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        if (s_rvalid_i && !fifo_empty) begin
            m_rvalid_o[fifo_head] = 1'b1;
            m_rdata_o             = s_rdata_i;
        end
    end

    // Next state: hold a stalled request, advance the pointer on acceptance, latch orphan rvalids.
    always_comb begin
        state_d   = ARB;
        hold_id_d = hold_id_q;
        ptr_d     = ptr_q;
        err_d     = err_q | (s_rvalid_i & fifo_empty);
        if (s_avalid_o && !s_ready_i) begin
            state_d   = HOLD;
            hold_id_d = grant;
        end
        if (handshake) begin
            ptr_d = grant;
        end
    end

    // Arbiter state registers, frozen while cke_i is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= ARB;
            ptr_q     <= ID_W'(N_MASTERS - 1);
            hold_id_q <= '0;
            err_q     <= 1'b0;
        end else if (cke_i) begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_id_q <= hold_id_d;
            err_q     <= err_d;
        end
    end

`ifdef IOB_RR_ARBITER_LOCK_EN
    // Lock follows the lock bit of each accepted request from its owner.
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (handshake) begin
            lock_d    = m_lock_i[grant];
            lock_id_d = grant;
        end
    end

    // Lock registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (cke_i) begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end
`endif

    assign err_o = err_q;

    iob_arb_owner_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .push_i   (fifo_push),
        .data_i   (grant),
        .pop_i    (fifo_pop),
        .head_o   (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Scoreboard bench for iob_rr_arbiter: a queue-based reference model predicts
// grants and read routing; a monitor process compares DUT handshakes and responses.
module tb_iob_rr_arbiter;

    localparam int N    = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXO = 4;

    typedef struct packed {
        logic [N-1:0]  ready;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    typedef struct packed {
        logic [N-1:0]  rvalid;
        logic [DW-1:0] rdata;
    } rsp_t;

    typedef struct {
        int          id;
        logic [AW-1:0] addr;
    } own_t;

    logic            clk;
    logic            arst_n_i;
    logic            cke_i;
    logic [N-1:0]    m_avalid_i;
    logic [N*AW-1:0] m_addr_i;
    logic [N*DW-1:0] m_wdata_i;
    logic [N*SW-1:0] m_wstrb_i;
    logic [N-1:0]    m_ready_o;
    logic [N-1:0]    m_rvalid_o;
    logic [DW-1:0]   m_rdata_o;
    logic            s_avalid_o;
    logic [AW-1:0]   s_addr_o;
    logic [DW-1:0]   s_wdata_o;
    logic [SW-1:0]   s_wstrb_o;
    logic            s_ready_i;
    logic            s_rvalid_i;
    logic [DW-1:0]   s_rdata_i;
    logic            err_o;
`ifdef IOB_RR_ARBITER_LOCK_EN
    logic [N-1:0]    m_lock_i = '0;
`endif

    iob_rr_arbiter #(
        .N_MASTERS       (N),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n_i),
        .cke_i      (cke_i),
`ifdef IOB_RR_ARBITER_LOCK_EN
        .m_lock_i   (m_lock_i),
`endif
        .m_avalid_i (m_avalid_i),
        .m_addr_i   (m_addr_i),
        .m_wdata_i  (m_wdata_i),
        .m_wstrb_i  (m_wstrb_i),
        .m_ready_o  (m_ready_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .s_avalid_o (s_avalid_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_wstrb_o  (s_wstrb_o),
        .s_ready_i  (s_ready_i),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i),
        .err_o      (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Master-side stimulus: one pending request per master.
    logic [N-1:0]  req_v;
    logic [AW-1:0] req_addr  [N];
    logic [DW-1:0] req_wdata [N];
    logic [SW-1:0] req_wstrb [N];
    int            acc [N];

    // Traffic knobs (percentages) and a spurious-rvalid strobe.
    int gen_pct, write_pct, ready_pct, rvalid_pct;
    bit spurious;

    // Slave model: read data still owed, in acceptance order.
    logic [DW-1:0] slv_q [$];

    // Reference model state.
    int   m_ptr;
    bit   m_hold;
    int   m_hold_id;
    bit   m_err;
    own_t m_own [$];
    req_t req_exp [$];
    rsp_t rsp_exp [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
        return 32'hCAFE_0000 ^ (a >> 4);
    endfunction

    task automatic model_reset();
        m_ptr  = N - 1;
        m_hold = 1'b0;
        m_hold_id = 0;
        m_err  = 1'b0;
        m_own.delete();
        req_exp.delete();
        rsp_exp.delete();
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
        req_v[k]     = 1'b1;
        req_addr[k]  = a;
        req_wdata[k] = d;
        req_wstrb[k] = s;
    endtask

    task automatic new_req(input int k);
        logic [SW-1:0] s;
        s = ($urandom_range(99) < write_pct) ? SW'($urandom_range(15, 1)) : '0;
        set_req(k, $urandom & 32'h0000_FFFC, $urandom, s);
    endtask

    // Reference model for one cycle: predict the slave request, then advance ownership and error state.
    task automatic model_cycle();
        bit   v;
        int   g;
        req_t e;
        rsp_t r;
        own_t o;
        check("err_o", err_o, m_err);
        v = 1'b0;
        g = 0;
        if (m_hold) begin
            g = m_hold_id;
            v = req_v[g];
        end else begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (!v && req_v[k] && (req_wstrb[k] != '0 || m_own.size() < MAXO)) begin
                    v = 1'b1;
                    g = k;
                end
            end
        end
        if (v) check("s_req", {s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o},
                     {1'b1, req_addr[g], req_wdata[g], req_wstrb[g]});
        else   check("s_req_idle", {s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o}, '0);
        if (v && s_ready_i) begin
            e.ready = N'(1 << g);
            e.addr  = req_addr[g];
            e.wdata = req_wdata[g];
            e.wstrb = req_wstrb[g];
            req_exp.push_back(e);
            m_ptr = g;
        end
        m_hold    = v && !s_ready_i;
        m_hold_id = g;
        if (s_rvalid_i) begin
            if (m_own.size() > 0) begin
                o = m_own.pop_front();
                r.rvalid = N'(1 << o.id);
                r.rdata  = rdata_of(o.addr);
                rsp_exp.push_back(r);
            end else begin
                m_err = 1'b1;
            end
        end
        if (v && s_ready_i && req_wstrb[g] == '0) begin
            o.id   = g;
            o.addr = req_addr[g];
            m_own.push_back(o);
        end
    endtask

    // One bus cycle: drive at negedge, run the model, let slave and masters react to the DUT.
    task automatic step();
        bit popped;
        @(negedge clk);
        arst_n_i = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (!req_v[k] && $urandom_range(99) < gen_pct) new_req(k);
        end
        for (int k = 0; k < N; k++) begin
            m_avalid_i[k]           = req_v[k];
            m_addr_i[k*AW +: AW]    = req_addr[k];
            m_wdata_i[k*DW +: DW]   = req_wdata[k];
            m_wstrb_i[k*SW +: SW]   = req_wstrb[k];
        end
        s_ready_i  = ($urandom_range(99) < ready_pct);
        popped     = (slv_q.size() > 0) && ($urandom_range(99) < rvalid_pct);
        s_rvalid_i = popped || spurious;
        s_rdata_i  = popped ? slv_q[0] : 32'hDEAD_BEEF;
        #1;
        model_cycle();
        if (popped) void'(slv_q.pop_front());
        if (s_avalid_o && s_ready_i && s_wstrb_o == '0) slv_q.push_back(rdata_of(s_addr_o));
        for (int k = 0; k < N; k++) begin
            if (m_ready_o[k]) begin
                req_v[k] = 1'b0;
                acc[k]++;
            end
        end
    endtask

    // Monitor: compare accepted requests and routed responses against the scoreboard queues.
    initial begin
        req_t er;
        rsp_t rr;
        bit   hs;
        forever begin
            @(negedge clk);
            #3;
            hs = s_avalid_o && s_ready_i;
            er = (req_exp.size() > 0) ? req_exp.pop_front() : '0;
            check("handshake", {m_ready_o, hs ? s_addr_o : '0, hs ? s_wdata_o : '0,
                                hs ? s_wstrb_o : '0}, er);
            rr = (rsp_exp.size() > 0) ? rsp_exp.pop_front() : '0;
            check("response", {m_rvalid_o, m_rdata_o}, rr);
        end
    end

    initial begin
        arst_n_i   = 1'b0;
        cke_i      = 1'b1;
        m_avalid_i = '0;
        m_addr_i   = '0;
        m_wdata_i  = '0;
        m_wstrb_i  = '0;
        s_ready_i  = 1'b0;
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        req_v      = '0;
        spurious   = 1'b0;
        gen_pct = 0; write_pct = 0; ready_pct = 100; rvalid_pct = 0;
        for (int k = 0; k < N; k++) begin
            req_addr[k] = '0; req_wdata[k] = '0; req_wstrb[k] = '0; acc[k] = 0;
        end
        model_reset();
        #2;
        check("reset_outputs", {s_avalid_o, m_ready_o, m_rvalid_o, m_rdata_o, err_o}, '0);

        // Idle after reset.
        repeat (3) step();

        // Two masters streaming writes share the slave evenly.
        gen_pct = 100; write_pct = 100; ready_pct = 100;
        for (int k = 0; k < N; k++) acc[k] = 0;
        repeat (8) step();
        check("share_m0", acc[0], 4);
        check("share_m1", acc[1], 4);
        gen_pct = 0;
        repeat (3) step();

        // Master 1 read held three cycles, data returned two cycles after acceptance.
        set_req(1, 32'h10, 32'h0, 4'h0);
        ready_pct = 0;   repeat (3) step();
        ready_pct = 100; step();
        ready_pct = 0;   step();
        rvalid_pct = 100; step();
        rvalid_pct = 0;  step();

        // Fill the owner FIFO with reads, then a write slips past the masked reads.
        gen_pct = 100; write_pct = 0; ready_pct = 100;
        repeat (6) step();
        gen_pct = 0;
        set_req(1, 32'h80, 32'h1234_5678, 4'hF);
        step();
        rvalid_pct = 100; step();
        rvalid_pct = 0;   step();
        rvalid_pct = 100; repeat (6) step();

        // Push and pop in the same cycle with one entry held.
        rvalid_pct = 0;
        set_req(0, 32'h100, 32'h0, 4'h0); step();
        set_req(1, 32'h200, 32'h0, 4'h0); rvalid_pct = 100; step();
        repeat (3) step();

        // Orphan rvalid sets the sticky error.
        rvalid_pct = 0; spurious = 1'b1; step();
        spurious = 1'b0; repeat (3) step();

        // Held master drops its request: arbitration resumes with no push.
        set_req(0, 32'h300, 32'h0, 4'h0);
        ready_pct = 0; repeat (2) step();
        req_v[0] = 1'b0; repeat (2) step();

        // Reset asserted mid-HOLD with a read outstanding; its late rvalid is an error.
        ready_pct = 100;
        set_req(0, 32'h40, 32'h0, 4'h0); step();
        set_req(1, 32'h20, 32'h0, 4'h0); ready_pct = 0; repeat (2) step();
        #1;
        arst_n_i = 1'b0;
        model_reset();
        #1;
        check("reset_mid_hold", {s_avalid_o, m_ready_o, s_addr_o, m_rvalid_o, err_o}, '0);
        step();
        rvalid_pct = 100; step();
        rvalid_pct = 0; ready_pct = 100; repeat (3) step();

        // Randomized traffic.
        gen_pct = 40; write_pct = 50; ready_pct = 70; rvalid_pct = 40;
        repeat (3000) step();

        // Drain.
        gen_pct = 0; ready_pct = 100; rvalid_pct = 100;
        repeat (30) step();
        @(negedge clk);
        #4;
        check("drained", req_exp.size() + rsp_exp.size() + m_own.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
